// File: rtl/peak_search_pkg.sv
// Shared types and width helpers for the peak search controller and its merge datapath.
package peak_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int stamp_width(input int clockwidth);
    return clockwidth + 1;
  endfunction

  function automatic int idx_width(input int phases);
    return (phases > 1) ? $clog2(phases) : 1;
  endfunction

  // Most negative metric; callers truncate to their metric width.
  function automatic logic signed [63:0] min_metric(input int mw);
    return -(64'sd1 <<< (mw - 1));
  endfunction

endpackage

// File: rtl/peak_search_ctrl_merge.sv
// peak_merge: combinational top-2 merge of a candidate beat into the running peaks.
module peak_merge
  import peak_search_pkg::*;
#(
  parameter int MW = 32,
  parameter int IW = 4,
  parameter int TW = 5
) (
  input  logic signed [MW-1:0] thresh,
  input  logic signed [MW-1:0] beat_max1,
  input  logic signed [MW-1:0] beat_max2,
  input  logic [IW-1:0]        beat_idx1,
  input  logic [IW-1:0]        beat_idx2,
  input  logic [TW-1:0]        stamp,
  input  logic signed [MW-1:0] cur_max1,
  input  logic signed [MW-1:0] cur_max2,
  input  logic [IW-1:0]        cur_idx1,
  input  logic [IW-1:0]        cur_idx2,
  input  logic [TW-1:0]        cur_clk1,
  input  logic [TW-1:0]        cur_clk2,
  output logic signed [MW-1:0] new_max1,
  output logic signed [MW-1:0] new_max2,
  output logic [IW-1:0]        new_idx1,
  output logic [IW-1:0]        new_idx2,
  output logic [TW-1:0]        new_clk1,
  output logic [TW-1:0]        new_clk2
);

  localparam logic signed [MW-1:0] MIN_METRIC = MW'(min_metric(MW));

  logic signed [MW-1:0] b1, b2;

  always_comb begin
    b1       = (beat_max1 < thresh) ? MIN_METRIC : beat_max1;
    b2       = (beat_max2 < thresh) ? MIN_METRIC : beat_max2;
    new_max1 = cur_max1;
    new_idx1 = cur_idx1;
    new_clk1 = cur_clk1;
    new_max2 = cur_max2;
    new_idx2 = cur_idx2;
    new_clk2 = cur_clk2;
    // >= everywhere so that ties go to the newest beat.
    if (b1 >= cur_max1) begin
      new_max1 = b1;
      new_idx1 = beat_idx1;
      new_clk1 = stamp;
      if (b2 >= cur_max1) begin
        new_max2 = b2;
        new_idx2 = beat_idx2;
        new_clk2 = stamp;
      end else begin
        new_max2 = cur_max1;
        new_idx2 = cur_idx1;
        new_clk2 = cur_clk1;
      end
    end else if (b1 >= cur_max2) begin
      new_max2 = b1;
      new_idx2 = beat_idx1;
      new_clk2 = stamp;
    end
  end

endmodule

// File: rtl/peak_search_ctrl.sv
// Windowed top-2 peak search controller with a valid/ready result port.
// Optional PEAK_SPACING_CHECK_EN adds res_spacing / res_period_ok outputs.
//
// state  | meaning
// IDLE   | waiting for start; start latches win_len and clears running peaks
// SEARCH | merging candidate beats until win_len beats seen
// DONE   | result presented, held until res_ready or abort
module peak_search_ctrl
  import peak_search_pkg::*;
#(
  parameter int DATAWIDTH   = 16,
  parameter int PHASES      = 16,
  parameter int PERIODICITY = 16,
  parameter int CLOCKWIDTH  = 4,
  localparam int MW = 2 * DATAWIDTH,
  localparam int IW = idx_width(PHASES),
  localparam int TW = stamp_width(CLOCKWIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [TW-1:0]        win_len,
  input  logic signed [MW-1:0] thresh,
  input  logic                 cand_valid,
  input  logic signed [MW-1:0] cand_max1,
  input  logic signed [MW-1:0] cand_max2,
  input  logic [IW-1:0]        cand_idx1,
  input  logic [IW-1:0]        cand_idx2,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_found,
  output logic signed [MW-1:0] res_max1,
  output logic signed [MW-1:0] res_max2,
  output logic [IW-1:0]        res_idx1,
  output logic [IW-1:0]        res_idx2,
  output logic [TW-1:0]        res_clk1,
  output logic [TW-1:0]        res_clk2
`ifdef PEAK_SPACING_CHECK_EN
  ,
  output logic [TW+IW-1:0]     res_spacing,
  output logic                 res_period_ok
`endif
);

  localparam logic signed [MW-1:0] MIN_METRIC = MW'(min_metric(MW));

  state_t               state;
  logic [TW-1:0]        beat_cnt, win_len_q;
  logic signed [MW-1:0] run_max1, run_max2, mrg_max1, mrg_max2, cap_max1, cap_max2;
  logic [IW-1:0]        run_idx1, run_idx2, mrg_idx1, mrg_idx2, cap_idx1, cap_idx2;
  logic [TW-1:0]        run_clk1, run_clk2, mrg_clk1, mrg_clk2, cap_clk1, cap_clk2;
  logic                 empty_win, final_beat, cap_found;

  peak_merge #(.MW(MW), .IW(IW), .TW(TW)) u_merge (
    .thresh    (thresh),
    .beat_max1 (cand_max1),
    .beat_max2 (cand_max2),
    .beat_idx1 (cand_idx1),
    .beat_idx2 (cand_idx2),
    .stamp     (beat_cnt),
    .cur_max1  (run_max1),
    .cur_max2  (run_max2),
    .cur_idx1  (run_idx1),
    .cur_idx2  (run_idx2),
    .cur_clk1  (run_clk1),
    .cur_clk2  (run_clk2),
    .new_max1  (mrg_max1),
    .new_max2  (mrg_max2),
    .new_idx1  (mrg_idx1),
    .new_idx2  (mrg_idx2),
    .new_clk1  (mrg_clk1),
    .new_clk2  (mrg_clk2)
  );

  assign empty_win  = (win_len_q == '0);
  assign final_beat = cand_valid && (beat_cnt == win_len_q - TW'(1));

  // Result source: an empty window publishes the untouched initial peaks.
  always_comb begin
    cap_max1 = empty_win ? run_max1 : mrg_max1;
    cap_max2 = empty_win ? run_max2 : mrg_max2;
    cap_idx1 = empty_win ? run_idx1 : mrg_idx1;
    cap_idx2 = empty_win ? run_idx2 : mrg_idx2;
    cap_clk1 = empty_win ? run_clk1 : mrg_clk1;
    cap_clk2 = empty_win ? run_clk2 : mrg_clk2;
  end

  assign cap_found = (cap_max1 != MIN_METRIC);

`ifdef PEAK_SPACING_CHECK_EN
  localparam int SW = TW + IW;
  logic [SW-1:0] cap_pos1, cap_pos2, cap_spacing, cap_abs;
  logic          cap_period_ok;

  assign cap_pos1      = SW'(cap_clk1) * SW'(PHASES) + SW'(cap_idx1);
  assign cap_pos2      = SW'(cap_clk2) * SW'(PHASES) + SW'(cap_idx2);
  assign cap_spacing   = cap_pos1 - cap_pos2;
  assign cap_abs       = cap_spacing[SW-1] ? (SW'(0) - cap_spacing) : cap_spacing;
  assign cap_period_ok = (cap_abs == SW'(PERIODICITY)) && cap_found;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_found <= 1'b0;
      res_max1  <= '0;
      res_max2  <= '0;
      res_idx1  <= '0;
      res_idx2  <= '0;
      res_clk1  <= '0;
      res_clk2  <= '0;
      beat_cnt  <= '0;
      win_len_q <= '0;
      run_max1  <= '0;
      run_max2  <= '0;
      run_idx1  <= '0;
      run_idx2  <= '0;
      run_clk1  <= '0;
      run_clk2  <= '0;
`ifdef PEAK_SPACING_CHECK_EN
      res_spacing   <= '0;
      res_period_ok <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SEARCH;
            busy      <= 1'b1;
            win_len_q <= win_len;
            beat_cnt  <= '0;
            run_max1  <= MIN_METRIC;
            run_max2  <= MIN_METRIC;
            run_idx1  <= '0;
            run_idx2  <= '0;
            run_clk1  <= '0;
            run_clk2  <= '0;
          end
        end
        ST_SEARCH: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (empty_win || final_beat) begin
            state     <= ST_DONE;
            res_valid <= 1'b1;
            res_found <= cap_found;
            res_max1  <= cap_max1;
            res_max2  <= cap_max2;
            res_idx1  <= cap_idx1;
            res_idx2  <= cap_idx2;
            res_clk1  <= cap_clk1;
            res_clk2  <= cap_clk2;
`ifdef PEAK_SPACING_CHECK_EN
            res_spacing   <= cap_spacing;
            res_period_ok <= cap_period_ok;
`endif
          end
          if (!abort && !empty_win && cand_valid) begin
            run_max1 <= mrg_max1;
            run_max2 <= mrg_max2;
            run_idx1 <= mrg_idx1;
            run_idx2 <= mrg_idx2;
            run_clk1 <= mrg_clk1;
            run_clk2 <= mrg_clk2;
            beat_cnt <= beat_cnt + TW'(1);
          end
        end
        ST_DONE: begin
          if (abort || res_ready) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peak_search_ctrl.sv
// Self-checking bench for peak_search_ctrl: directed cases plus randomized traffic vs. a top-2 model.
module tb_peak_search_ctrl;

  localparam int DW = 16, PH = 16, PER = 16, CW = 4;
  localparam int MW = 2 * DW, IW = 4, TW = CW + 1, SW = TW + IW;
  localparam longint MINL = -(longint'(1) << (MW - 1));

  logic                 clk, rst_n, start, abort, cand_valid, res_ready;
  logic [TW-1:0]        win_len;
  logic signed [MW-1:0] thresh, cand_max1, cand_max2;
  logic [IW-1:0]        cand_idx1, cand_idx2;
  logic                 busy, res_valid, res_found;
  logic signed [MW-1:0] res_max1, res_max2;
  logic [IW-1:0]        res_idx1, res_idx2;
  logic [TW-1:0]        res_clk1, res_clk2;
`ifdef PEAK_SPACING_CHECK_EN
  logic [SW-1:0]        res_spacing;
  logic                 res_period_ok;
`endif

  peak_search_ctrl #(.DATAWIDTH(DW), .PHASES(PH), .PERIODICITY(PER), .CLOCKWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_len(win_len),
    .thresh(thresh), .cand_valid(cand_valid), .cand_max1(cand_max1), .cand_max2(cand_max2),
    .cand_idx1(cand_idx1), .cand_idx2(cand_idx2), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_found(res_found), .res_max1(res_max1), .res_max2(res_max2),
    .res_idx1(res_idx1), .res_idx2(res_idx2), .res_clk1(res_clk1), .res_clk2(res_clk2)
`ifdef PEAK_SPACING_CHECK_EN
    , .res_spacing(res_spacing), .res_period_ok(res_period_ok)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 searching, 2 result held.
  int     m_phase, m_cnt, m_wl;
  longint top_m[2];
  int     top_i[2], top_c[2];
  int     e_busy, e_valid, e_found, e_idx1, e_idx2, e_clk1, e_clk2, e_spacing, e_ok;
  longint e_max1, e_max2;

  task automatic insert_peak(input longint m, input int i, input int c);
    if (m >= top_m[0]) begin
      top_m[1] = top_m[0]; top_i[1] = top_i[0]; top_c[1] = top_c[0];
      top_m[0] = m;        top_i[0] = i;        top_c[0] = c;
    end else if (m >= top_m[1]) begin
      top_m[1] = m; top_i[1] = i; top_c[1] = c;
    end
  endtask

  task automatic publish();
    int d;
    m_phase = 2;
    e_max1 = top_m[0]; e_idx1 = top_i[0]; e_clk1 = top_c[0];
    e_max2 = top_m[1]; e_idx2 = top_i[1]; e_clk2 = top_c[1];
    e_found = (top_m[0] > MINL) ? 1 : 0;
    d = (top_c[0] * PH + top_i[0]) - (top_c[1] * PH + top_i[1]);
    d = ((d % (1 << SW)) + (1 << SW)) % (1 << SW);
    e_spacing = d;
    if (d >= (1 << (SW - 1))) d = d - (1 << SW);
    e_ok = ((d == PER || d == -PER) && e_found == 1) ? 1 : 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic a, input logic rr,
                            input int wl, input longint th, input logic cv,
                            input longint b1, input int j1, input longint b2, input int j2);
    if (!r) begin
      m_phase = 0; m_cnt = 0; m_wl = 0;
      top_m = '{0, 0}; top_i = '{0, 0}; top_c = '{0, 0};
      e_found = 0; e_max1 = 0; e_max2 = 0; e_idx1 = 0; e_idx2 = 0;
      e_clk1 = 0; e_clk2 = 0; e_spacing = 0; e_ok = 0;
    end else begin
      case (m_phase)
        0: if (s) begin
             m_phase = 1; m_cnt = 0; m_wl = wl;
             top_m = '{MINL, MINL}; top_i = '{0, 0}; top_c = '{0, 0};
           end
        1: if (a) m_phase = 0;
           else if (m_wl == 0) publish();
           else if (cv) begin
             insert_peak((b2 < th) ? MINL : b2, j2, m_cnt);
             insert_peak((b1 < th) ? MINL : b1, j1, m_cnt);
             m_cnt++;
             if (m_cnt == m_wl) publish();
           end
        default: if (a || rr) m_phase = 0;
      endcase
    end
    e_busy  = (m_phase != 0) ? 1 : 0;
    e_valid = (m_phase == 2) ? 1 : 0;
  endtask

  initial begin
    logic   s_r, s_s, s_a, s_rr, s_cv;
    int     s_wl, s_j1, s_j2;
    longint s_th, s_b1, s_b2;
    forever begin
      @(posedge clk);
      s_r = rst_n; s_s = start; s_a = abort; s_rr = res_ready; s_cv = cand_valid;
      s_wl = int'(win_len); s_th = thresh; s_b1 = cand_max1; s_b2 = cand_max2;
      s_j1 = int'(cand_idx1); s_j2 = int'(cand_idx2);
      #1;
      model_step(s_r, s_s, s_a, s_rr, s_wl, s_th, s_cv, s_b1, s_j1, s_b2, s_j2);
      check("busy", busy, e_busy);
      check("res_valid", res_valid, e_valid);
      check("res_found", res_found, e_found);
      check("res_max1", res_max1, e_max1);
      check("res_max2", res_max2, e_max2);
      check("res_idx1", res_idx1, e_idx1);
      check("res_idx2", res_idx2, e_idx2);
      check("res_clk1", res_clk1, e_clk1);
      check("res_clk2", res_clk2, e_clk2);
`ifdef PEAK_SPACING_CHECK_EN
      check("res_spacing", res_spacing, e_spacing);
      check("res_period_ok", res_period_ok, e_ok);
`endif
    end
  end

  task automatic idle_inputs();
    start = 0; abort = 0; cand_valid = 0; res_ready = 0;
    cand_max1 = '0; cand_max2 = '0; cand_idx1 = '0; cand_idx2 = '0;
  endtask

  task automatic do_start(input int wl, input longint th);
    @(negedge clk);
    idle_inputs();
    start = 1; win_len = TW'(wl); thresh = MW'(th);
    @(negedge clk);
    start = 0;
  endtask

  task automatic beat(input longint b1, input int j1, input longint b2, input int j2);
    cand_valid = 1; cand_max1 = MW'(b1); cand_max2 = MW'(b2);
    cand_idx1 = IW'(j1); cand_idx2 = IW'(j2);
    @(negedge clk);
    cand_valid = 0;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (!res_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, res_valid, 1);
  endtask

  task automatic handshake();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    check("hs_valid_drop", res_valid, 0);
    check("hs_busy_drop", busy, 0);
  endtask

  function automatic longint rnd_metric(input longint th);
    case ($urandom_range(0, 4))
      0:       return 100;
      1:       return th;
      default: return longint'($urandom_range(0, 4000)) - 2000;
    endcase
  endfunction

  initial begin
    longint a, b;
    rst_n = 0; win_len = '0; thresh = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_max1", res_max1, 0);
    rst_n = 1;

    // Mixed window: ties go to the later beat.
    do_start(4, 100);
    beat(50, 3, 10, 0); beat(300, 5, 20, 1); beat(200, 7, 30, 2); beat(300, 9, 40, 4);
    wait_valid(0, "a_latency");
    check("a_max1", res_max1, 300); check("a_idx1", res_idx1, 9); check("a_clk1", res_clk1, 3);
    check("a_max2", res_max2, 300); check("a_idx2", res_idx2, 5); check("a_clk2", res_clk2, 1);
    check("a_found", res_found, 1);
    repeat (10) begin
      @(negedge clk);
      check("a_hold_busy", busy, 1);
      check("a_hold_max1", res_max1, 300);
    end
    handshake();

    // Everything below threshold.
    do_start(3, 1000);
    beat(500, 1, 400, 2); beat(999, 2, -5, 3); beat(0, 0, -100, 1);
    wait_valid(0, "b_latency");
    check("b_found", res_found, 0);
    check("b_max1", res_max1, MINL);
    handshake();

    // Abort on the final beat, then a clean run.
    do_start(2, 0);
    beat(10, 1, 5, 2);
    abort = 1;
    beat(77, 3, 1, 4);
    abort = 0;
    check("c_no_valid", res_valid, 0);
    check("c_idle", busy, 0);
    do_start(1, 0);
    beat(5, 6, 3, 7);
    wait_valid(0, "c2_latency");
    check("c2_max1", res_max1, 5); check("c2_idx1", res_idx1, 6);
    check("c2_max2", res_max2, 3); check("c2_idx2", res_idx2, 7); check("c2_clk2", res_clk2, 0);
    handshake();

    // Reset mid-search, then an empty window.
    do_start(5, 0);
    beat(40, 1, 20, 2);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("d_busy", busy, 0); check("d_valid", res_valid, 0);
    check("d_max1", res_max1, 0); check("d_idx1", res_idx1, 0);
    do_start(0, 0);
    check("d_wl0_busy", busy, 1);
    check("d_wl0_pending", res_valid, 0);
    @(negedge clk);
    check("d_wl0_valid", res_valid, 1);
    check("d_wl0_found", res_found, 0);
    handshake();

    // Peaks one period apart.
    do_start(3, 0);
    beat(-5, 1, -9, 2); beat(500, 4, -1, 3); beat(600, 4, -2, 5);
    wait_valid(0, "e_latency");
    check("e_max1", res_max1, 600); check("e_clk1", res_clk1, 2); check("e_idx1", res_idx1, 4);
    check("e_max2", res_max2, 500); check("e_clk2", res_clk2, 1); check("e_idx2", res_idx2, 4);
`ifdef PEAK_SPACING_CHECK_EN
    check("e_spacing", res_spacing, 16);
    check("e_period_ok", res_period_ok, 1);
`endif
    handshake();

    // Randomized traffic, checked every cycle by the model.
    thresh = MW'(0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(0, 499) != 0);
      start      = ($urandom_range(0, 2) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      res_ready  = ($urandom_range(0, 2) == 0);
      cand_valid = ($urandom_range(0, 2) != 0);
      win_len    = ($urandom_range(0, 9) == 0) ? TW'($urandom_range(0, 31)) : TW'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) thresh = MW'(longint'($urandom_range(0, 2000)) - 1000);
      a = rnd_metric(thresh);
      b = rnd_metric(thresh);
      if (b > a) begin cand_max1 = MW'(b); cand_max2 = MW'(a); end
      else       begin cand_max1 = MW'(a); cand_max2 = MW'(b); end
      cand_idx1 = IW'($urandom_range(0, PH - 1));
      cand_idx2 = IW'($urandom_range(0, PH - 1));
    end

    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peak_search_ctrl.md
PEAK_SEARCH_CTRL -- requirements
Module: peak_search_ctrl

Interface
REQ-001 SHALL have parameters: DATAWIDTH, default 16, sample width; PHASES, default 16, parallel phases; PERIODICITY, default 16, LTF period in samples; CLOCKWIDTH, default 4, so cycle stamps are CLOCKWIDTH+1 bits wide.
REQ-002 SHALL have ports, one clock and one reset, with reset synchronous and active-low:
  clk  in  1  sole clock
  rst_n  in  1  synchronous active-low reset
  start  in  1  arm a search (sampled in IDLE only)
  abort  in  1  cancel search or result
  win_len  in  CLOCKWIDTH+1  candidate beats per window
  thresh  in  2*DATAWIDTH signed  minimum accepted metric
  cand_valid  in  1  candidate beat present
  cand_max1, cand_max2  in  2*DATAWIDTH signed  beat top-2 metrics
  cand_idx1, cand_idx2  in  clog2(PHASES)  phase indices of beat top-2
  busy  out  1  state != IDLE
  res_valid  out  1  result available
  res_ready  in  1  result consumed
  res_found  out  1  at least one metric >= thresh merged
  res_max1, res_max2  out  2*DATAWIDTH signed  window top-2
  res_idx1, res_idx2  out  clog2(PHASES)  phase indices
  res_clk1, res_clk2  out  CLOCKWIDTH+1  beat stamps of top-2

Function
REQ-003 SHALL implement states IDLE, SEARCH, DONE; next-state transitions are registered.
REQ-004 IDLE: start=1 -> SEARCH; running top-2 metrics are set to MIN_METRIC (-2^(2*DATAWIDTH-1)), indices and stamps are set to 0, beat counter is set to 0, and win_len is latched.
REQ-005 SEARCH: on each cand_valid beat, the running top-2 merges with the beat top-2 through peak_merge, then the beat counter increments; a cand_valid=0 cycle changes nothing.
REQ-006 Merge rule: a beat metric < thresh is replaced by MIN_METRIC before comparison.
REQ-007 Merge rule: a new metric >= stored metric displaces it (ties favour the latest beat); the displaced max1 moves to max2.
REQ-008 Merge rule: a beat max1 that beats only the stored max2 replaces max2.
REQ-009 Merge rule: the stamp of each new entry equals the beat counter value on that beat.
REQ-010 SEARCH -> DONE on the beat where the counter equals latched win_len-1; res_valid SHALL rise the following cycle, so latency from the final beat is 1 cycle.
REQ-011 latched win_len=0: SEARCH -> DONE after one cycle with no beats merged; res_found=0.
REQ-012 DONE: res_valid=1; res_* SHALL be held stable until res_ready=1; handshake cycle -> IDLE, and res_valid drops next cycle.
REQ-013 res_found=1 iff the final max1 > MIN_METRIC; res_* values are registered copies of the running state.
REQ-014 abort=1 in SEARCH or DONE -> IDLE next cycle with no result; abort wins over a simultaneous final beat or res_ready.
REQ-015 start outside IDLE is ignored; cand_valid outside SEARCH is ignored.
REQ-016 Beat counter SHALL never wrap within a window, because win_len is at most 2^(CLOCKWIDTH+1)-1.

Reset
REQ-017 rst_n=0 at a clock edge -> IDLE, and busy, res_valid, res_found, all res_* and all internal registers are 0; this applies mid-SEARCH or mid-DONE as well.

Configuration
REQ-018 PEAK_SPACING_CHECK_EN defined: adds outputs res_spacing (CLOCKWIDTH+1+clog2(PHASES) bits) = (res_clk1*PHASES+res_idx1) - (res_clk2*PHASES+res_idx2) in modulo arithmetic, and res_period_ok = (|res_spacing| == PERIODICITY) && res_found; both are registered with the other res_*, reset to 0.
REQ-019 PEAK_SPACING_CHECK_EN undefined: these ports and logic are absent; all other behaviour is identical.

Structure
REQ-020 Package peak_search_pkg SHALL hold the state enum, MIN_METRIC and the stamp/index width helpers.
REQ-021 Sub-module peak_merge SHALL be purely combinational and implement REQ-006 to REQ-009; the controller holds all registers.

Verification
REQ-022 win_len=4, thresh=100, beat metrics max1 = 50,300,200,300 (idx 3,5,7,9) -> res_max1=300 idx9 clk3; res_max2=300 idx5 clk1; res_found=1.
REQ-023 win_len=3, every metric < thresh -> res_valid after 3 beats, res_found=0, res_max1=MIN_METRIC.
REQ-024 Hold res_ready=0 for 10 cycles in DONE -> res_* stable and busy=1; res_ready=1 -> IDLE next cycle.
REQ-025 abort on the final SEARCH beat -> no res_valid; IDLE; a following start runs clean with no stale peaks.
REQ-026 rst_n=0 mid-SEARCH and win_len=0 run -> all outputs 0 after reset; win_len=0 gives res_valid 2 cycles after start with res_found=0.
REQ-027 With PEAK_SPACING_CHECK_EN, peaks at (clk2 idx4) and (clk1 idx4), PHASES=16 -> res_spacing=16, res_period_ok=1.
